// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT pipeline read-side blocks.
//   FFT_DATA_WIDTH : default sample width, matching the stage FIFOs.
//   fsm_state_t    : frame reader control states (2 bits).
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/fft_out_buffer.sv
// ---------------------------------------------------------------------------
// fft_out_buffer
// Small circular output buffer between the FIFO read port and the output
// stream. Push and pop may occur in the same cycle. Only the pointers and
// occupancy are reset; the storage itself carries data only.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_data at the tail
//   push_data   : sample to store
//   pop         : remove the head entry
//   head_data   : current head entry (meaningful only when occ != 0)
//   occ         : number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module fft_out_buffer
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int DEPTH      = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [AW:0]           occ
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  pop_ok;
    logic                  push_ok;

    // A pop on an empty buffer or a push into a full one (without a
    // matching pop) would corrupt the pointers, so both are masked here.
    assign pop_ok  = pop && (occ != '0);
    assign push_ok = push && ((occ != (AW+1)'(DEPTH)) || pop_ok);

    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/fft_frame_reader.sv
// ---------------------------------------------------------------------------
// fft_frame_reader
// Drains one frame of FRAME_LEN samples from the stage FIFO's registered
// read port after a start pulse and re-emits them as a valid/ready stream
// with first/last/index tags, absorbing downstream backpressure.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : frame request, honoured only while idle
//   fifo_empty  : FIFO empty flag
//   fifo_dout   : FIFO read data, valid the cycle after an accepted read
//   fifo_rd_en  : FIFO read enable (combinational)
//   m_valid     : output beat valid
//   m_ready     : downstream accept
//   m_data      : output sample (0 when no beat is presented)
//   m_first     : beat is index 0
//   m_last      : beat is index FRAME_LEN-1
//   m_index     : beat index within the frame
//   busy        : controller is not idle
//   done        : one-cycle pulse after the last beat is accepted
// ---------------------------------------------------------------------------
module fft_frame_reader
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int FRAME_LEN  = 8,
    parameter int OBUF_DEPTH = 4,
    localparam int IW        = $clog2(FRAME_LEN),
    localparam int OW        = $clog2(OBUF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_first,
    output logic                  m_last,
    output logic [IW-1:0]         m_index,
    output logic                  busy,
    output logic                  done
);

    fsm_state_t            state;
    logic [IW:0]           rd_left;
    logic [IW-1:0]         tx_cnt;
    logic                  inflight;
    logic [OW:0]           occ;
    logic [OW+1:0]         pending;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  hs;
    logic                  last_beat;

    // Reads are throttled so that everything already requested, including
    // the word still on its way out of the FIFO, fits in the buffer.
    assign pending    = {1'b0, occ} + (OW+2)'(inflight);
    assign fifo_rd_en = (state == ST_RUN) && (rd_left != '0) && !fifo_empty &&
                        (pending < (OW+2)'(OBUF_DEPTH));

    assign m_valid   = (occ != '0);
    assign hs        = m_valid && m_ready;
    assign last_beat = (tx_cnt == IW'(FRAME_LEN - 1));

    // Tags and data are gated by m_valid so idle/reset outputs read as zero
    // without having to reset the buffer storage.
    assign m_data  = m_valid ? head_data : '0;
    assign m_index = tx_cnt;
    assign m_first = m_valid && (tx_cnt == '0);
    assign m_last  = m_valid && last_beat;
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rd_left  <= '0;
            tx_cnt   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        rd_left <= (IW+1)'(FRAME_LEN);
                        tx_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    if (fifo_rd_en) begin
                        rd_left <= rd_left - 1'b1;
                    end
                    // The final read cannot have produced a beat yet, so the
                    // last handshake always happens in DRAIN.
                    if (rd_left == '0 || (fifo_rd_en && rd_left == (IW+1)'(1))) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (hs && last_beat) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            // tx_cnt wraps back to 0 after the last beat of the frame.
            if (hs) begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    fft_out_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OBUF_DEPTH)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (fifo_dout),
        .pop       (hs),
        .head_data (head_data),
        .occ       (occ)
    );

endmodule

// File: doc/fft_frame_reader.md
# fft_frame_reader

Read-side controller for the FFT pipeline delay/reorder FIFO. On a `start` pulse it drains exactly one frame of `FRAME_LEN` samples from the FIFO's registered read port and re-emits them as a valid/ready stream tagged with first/last/index markers. It sits between the stage FIFO and the next butterfly stage (or the output DMA) and absorbs downstream backpressure without losing or duplicating samples.

## Interface
- `DATA_WIDTH`, 16, sample width (matches the FIFO).
- `FRAME_LEN`, 8, samples per frame; power of two, ≥2.
- `OBUF_DEPTH`, 4, output buffer entries; power of two, ≥4.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: frame request pulse; sampled only in IDLE.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_dout` in DATA_WIDTH: FIFO registered read data.
- `fifo_rd_en` out 1: FIFO read enable (combinational).
- `m_valid` out 1: output beat valid.
- `m_ready` in 1: downstream accept.
- `m_data` out DATA_WIDTH: sample.
- `m_first` out 1: beat index 0.
- `m_last` out 1: beat index FRAME_LEN-1.
- `m_index` out $clog2(FRAME_LEN): beat index within the frame.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse after the last beat is accepted.

## Operation
- FIFO contract: `fifo_dout` is valid in the cycle after an edge where `fifo_rd_en && !fifo_empty`. The FIFO ignores reads when empty, so `fifo_rd_en` is never asserted while `fifo_empty`=1.
- FSM states:
  - IDLE: `start` → RUN; clears `rd_left`=FRAME_LEN and `tx_cnt`=0.
  - RUN: issue reads; when `rd_left` reaches 0 → DRAIN.
  - DRAIN: wait for the last accepted beat → DONE.
  - DONE: one cycle, `done`=1 → IDLE.
- `fifo_rd_en` = RUN && `rd_left`≠0 && !`fifo_empty` && (`occ` + `inflight`) < OBUF_DEPTH.
- `inflight` (1 bit) is the registered copy of `fifo_rd_en`. When `inflight`=1, `fifo_dout` is pushed into the output buffer that cycle.
- Output buffer: the push and pop in the same cycle are both legal, and `occ` is unchanged. `m_valid` = `occ`≠0. The head entry drives `m_data`.
- `tx_cnt` increments on `m_valid && m_ready` and drives `m_index`. `m_first` = (`tx_cnt`==0); `m_last` = (`tx_cnt`==FRAME_LEN-1).
- Handshake: while `m_valid && !m_ready`, `m_data`, `m_index`, `m_first` and `m_last` hold stable.
- `start` outside IDLE is ignored; no queuing.
- Reset, at any time including mid-frame: state IDLE; counters, `occ` and `inflight` cleared; buffered data discarded. No reads are issued until the next `start`. The FIFO is not flushed by this block.

## Timing
- Reset values: `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `m_first`=0, `m_last`=0, `m_index`=0, `busy`=0, `done`=0. `m_first` is gated by `m_valid`.
- Start latency: `start` in cycle t, FIFO non-empty → `fifo_rd_en` in t+1, data in the buffer at edge t+2 → `m_valid` first high in t+3.
- Throughput: one beat per cycle with `m_ready`=1 and the FIFO non-empty, because `occ`+`inflight` ≤ 2 in steady state.
- `done` asserts the cycle after the final handshake. `start` in the `done` cycle is ignored; it is accepted from the following cycle (IDLE).
- Empty FIFO mid-frame: reads stall, and already-buffered beats continue to drain.

## Structure
- Shared package `fft_pkg`: `DATA_WIDTH` default, and the FSM state enum (IDLE, RUN, DRAIN, DONE, 2 bits).
- Sub-module `fft_out_buffer`: OBUF_DEPTH-entry synchronous buffer with simultaneous push/pop and an `occ` output, carrying data only. Index, first and last are derived in the parent.

## Test plan
- Basic frame: FRAME_LEN=8, FIFO preloaded with 1..8, `m_ready`=1, `start` pulse → beats 1..8 on consecutive cycles from t+3; `m_first` on 1, `m_last` on 8, `m_index` 0..7; `done` one cycle later.
- Backpressure: toggle `m_ready` 1010…, plus a 6-cycle low burst → same 1..8 sequence, outputs stable while stalled, `fifo_rd_en` stops once `occ`+`inflight`=4, no loss or duplication.
- Underflow: FIFO holds 3 samples, then 5 more arrive 10 cycles later → `fifo_rd_en` never high while empty, 8 beats total, `done` once.
- `start` while busy: pulse at beat 4 → ignored; exactly 8 beats and a single `done`.
- Reset mid-frame: assert `rst` after beat 3 → all outputs return to reset values on the same cycle (asynchronous). A subsequent `start` yields a frame starting with `m_index`=0 and the next FIFO word.
- Back-to-back: `start` on the cycle after `done`, FIFO holding 16 samples → second frame 9..16 with a correct `m_first`/`m_last`.
